// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction fetch front end for the synchronous imem SRAM
// Holds the PC, issues one SRAM read per cycle and buffers returned words for decode.
module imem_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_dec_ready,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_read,
    input  logic [31:0] i_imem_rd_data
);

    localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;
    localparam logic [2:0]  DEPTH      = 3'(BUF_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;

    logic        deq;
    logic        push;
    logic        issue;
    logic [2:0]  occ;
    logic [31:0] target;

    assign target = i_redirect_pc & ~32'h3;
    assign deq    = (count_q != 2'd0) & i_dec_ready;
    assign push   = inflight_q & (count_q < 2'(DEPTH) | deq);
    assign occ    = {1'b0, count_q} + {2'b00, inflight_q};
    // Counting the word already in flight keeps the buffer from ever overflowing.
    assign issue  = (occ - {2'b00, deq}) < DEPTH;

    always_comb begin
        o_imem_read = 1'b0;
        o_imem_addr = pc_q;
        if (i_rst) begin
            o_imem_addr = RESET_PC_A;
        end else if (i_redirect) begin
            o_imem_read = 1'b1;
            o_imem_addr = target;
        end else if (issue) begin
            o_imem_read = 1'b1;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        head_instr_d  = head_instr_q;
        head_pc_d     = head_pc_q;
        tail_instr_d  = tail_instr_q;
        tail_pc_d     = tail_pc_q;

        if (i_redirect) begin
            // The returning word and every buffered entry belong to the old path.
            count_d       = 2'd0;
            pc_d          = target + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = target;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end

            if (push && deq) begin
                if (count_q == 2'd1) begin
                    head_instr_d = i_imem_rd_data;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    tail_instr_d = i_imem_rd_data;
                    tail_pc_d    = inflight_pc_q;
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    head_instr_d = i_imem_rd_data;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    tail_instr_d = i_imem_rd_data;
                    tail_pc_d    = inflight_pc_q;
                end
                count_d = count_q + 2'd1;
            end else if (deq) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                count_d      = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q          <= RESET_PC_A;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            count_q       <= 2'd0;
            head_instr_q  <= 32'd0;
            head_pc_q     <= 32'd0;
            tail_instr_q  <= 32'd0;
            tail_pc_q     <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
            tail_instr_q  <= tail_instr_d;
            tail_pc_q     <= tail_pc_d;
        end
    end

    assign o_instr_valid = (count_q != 2'd0);
    assign o_instr       = head_instr_q;
    assign o_instr_pc    = head_pc_q;

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - scoreboard bench for imem_fetch with a 1-cycle SRAM model
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        i_dec_ready = 1'b1;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic [31:0] o_imem_addr;
    logic        o_imem_read;
    logic [31:0] i_imem_rd_data = 32'd0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    imem_fetch dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_dec_ready    (i_dec_ready),
        .o_instr_valid  (o_instr_valid),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .o_imem_addr    (o_imem_addr),
        .o_imem_read    (o_imem_read),
        .i_imem_rd_data (i_imem_rd_data)
    );

    always #5 clk = ~clk;

    // SRAM preloaded with mem[k] = 0x1000_0000 + k
    always @(posedge clk) begin
        if (o_imem_read)
            i_imem_rd_data <= 32'h1000_0000 + {22'd0, o_imem_addr[11:2]};
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        for (int k = 0; k < 64; k++)
            sb_q.push_back(start + 32'(k * 4));
    endtask

    task automatic tick();
        logic [31:0] exp_pc;
        if (!i_rst && !i_redirect && o_instr_valid && i_dec_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_pc = sb_q.pop_front();
                chk("deq_pc", o_instr_pc, exp_pc);
                chk("deq_instr", o_instr, mem_word(exp_pc));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        i_rst = 1'b1;
        i_dec_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_read", {31'd0, o_imem_read}, 32'd0);
        chk("rst_addr", o_imem_addr, 32'd0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_instr_pc, 32'd0);
        tick();

        // Streaming from RESET_PC with no bubbles
        i_rst = 1'b0;
        sb_restart(32'd0);
        #1;
        for (int c = 0; c < 22; c++) begin
            chk("stream_read", {31'd0, o_imem_read}, 32'd1);
            chk("stream_addr", o_imem_addr, 32'(c * 4));
            chk("stream_valid", {31'd0, o_instr_valid}, (c >= 2) ? 32'd1 : 32'd0);
            tick();
        end

        // Decode stall: head frozen, issue stops
        i_dec_ready = 1'b0;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("stall_read", {31'd0, o_imem_read}, 32'd0);
            chk("stall_valid", {31'd0, o_instr_valid}, 32'd1);
            chk("stall_pc", o_instr_pc, sb_q[0]);
            chk("stall_instr", o_instr, mem_word(sb_q[0]));
            tick();
        end
        i_dec_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("resume_valid", {31'd0, o_instr_valid}, 32'd1);
            tick();
        end

        // Redirect during streaming, unaligned target
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0103;
        sb_restart(32'h0000_0100);
        #1;
        chk("redir_read", {31'd0, o_imem_read}, 32'd1);
        chk("redir_addr", o_imem_addr, 32'h0000_0100);
        tick();
        i_redirect = 1'b0;
        #1;
        chk("redir_valid_off", {31'd0, o_instr_valid}, 32'd0);
        tick();
        chk("redir_valid_on", {31'd0, o_instr_valid}, 32'd1);
        chk("redir_first_pc", o_instr_pc, 32'h0000_0100);
        chk("redir_first_instr", o_instr, mem_word(32'h0000_0100));
        for (int c = 0; c < 5; c++) tick();

        // Redirect with buffer full and decode accepting
        i_dec_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("full_read", {31'd0, o_imem_read}, 32'd0);
        i_dec_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        sb_restart(32'h0000_0200);
        #1;
        chk("full_redir_addr", o_imem_addr, 32'h0000_0200);
        tick();
        i_redirect = 1'b0;
        #1;
        chk("full_redir_valid_off", {31'd0, o_instr_valid}, 32'd0);
        tick();
        chk("full_redir_pc", o_instr_pc, 32'h0000_0200);
        for (int c = 0; c < 4; c++) tick();

        // Back-to-back redirects: only the last target survives
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0300;
        sb_restart(32'h0000_0300);
        #1;
        tick();
        i_redirect_pc = 32'h0000_0400;
        sb_restart(32'h0000_0400);
        #1;
        chk("b2b_addr", o_imem_addr, 32'h0000_0400);
        tick();
        i_redirect = 1'b0;
        #1;
        chk("b2b_valid_off", {31'd0, o_instr_valid}, 32'd0);
        tick();
        chk("b2b_pc", o_instr_pc, 32'h0000_0400);
        for (int c = 0; c < 4; c++) tick();

        // Reset mid-stream with buffer full
        i_dec_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        i_rst = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_rst_read", {31'd0, o_imem_read}, 32'd0);
        chk("mid_rst_addr", o_imem_addr, 32'd0);
        tick();
        i_rst = 1'b0;
        i_dec_ready = 1'b1;
        sb_restart(32'd0);
        #1;
        chk("post_rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("post_rst_addr", o_imem_addr, 32'd0);
        chk("post_rst_read", {31'd0, o_imem_read}, 32'd1);
        tick();
        tick();
        chk("post_rst_pc", o_instr_pc, 32'd0);
        for (int c = 0; c < 4; c++) tick();

        // PC wrap at the top of the address space
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        sb_restart(32'hFFFF_FFF8);
        #1;
        chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFF8);
        tick();
        i_redirect = 1'b0;
        #1;
        chk("wrap_addr1", o_imem_addr, 32'hFFFF_FFFC);
        chk("wrap_read1", {31'd0, o_imem_read}, 32'd1);
        tick();
        chk("wrap_addr2", o_imem_addr, 32'h0000_0000);
        chk("wrap_pc0", o_instr_pc, 32'hFFFF_FFF8);
        for (int c = 0; c < 6; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
